// File: rtl/lcd_hex_display.sv
// lcd_hex_display: HD44780-style LCD driver showing a 4*DIGITS-bit value as upper-case hex on line 1
module lcd_hex_display #(
    parameter int DIGITS  = 4,
    parameter int T_PWR   = 2_000_000,
    parameter int T_SETUP = 4,
    parameter int T_EN    = 16,
    parameter int T_HOLD  = 4,
    parameter int T_CMD   = 2_500,
    parameter int T_CLR   = 100_000
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [4*DIGITS-1:0]   iVALUE,
    input  logic                  iBLANK_LZ,
    output logic                  oREADY,
    output logic                  oDONE,
    output logic [7:0]            oLCD_DATA,
    output logic                  oLCD_RS,
    output logic                  oLCD_RW,
    output logic                  oLCD_EN
);
    localparam logic [4:0] LAST   = 5'(DIGITS - 1);
    localparam logic [6:0] MSB_SH = 7'(4 * (DIGITS - 1));

    typedef enum logic [2:0] {PWR_WAIT, INIT, SNAP, HOME, CHAR, DONE} state_t;
    typedef enum logic [1:0] {SETUP, EN_HI, HOLD, WAIT} phase_t;

    state_t              state;
    phase_t              phase;
    logic [31:0]         cnt;
    logic [4:0]          idx;
    logic [4*DIGITS-1:0] snap;
    logic                blank;
    logic                lead;
    logic [31:0]         wait_len;
    logic                pwr_end;
    logic                ph_end;
    logic                wr_end;
    logic                start;
    logic                nrs;
    logic                lz;
    logic [4:0]          ci;
    logic [3:0]          nib;
    logic [7:0]          ch;
    logic [7:0]          nb;

    assign oLCD_RW = 1'b0;

    // Phase/write completion and selection of the next byte to put on the bus
    always_comb begin
        wait_len = (oLCD_DATA == 8'h01) ? 32'(T_CLR) : 32'(T_CMD);
        pwr_end  = (T_PWR == 0) || (cnt == 32'(T_PWR - 1));
        ph_end   = cnt == (phase == SETUP ? 32'(T_SETUP - 1) :
                           phase == EN_HI ? 32'(T_EN - 1) :
                           phase == HOLD  ? 32'(T_HOLD - 1) : wait_len - 32'd1);
        wr_end   = ph_end && ((phase == HOLD && wait_len == 32'd0) || phase == WAIT);
        ci       = (state == CHAR) ? idx + 5'd1 : 5'd0;
        nib      = 4'(snap >> (MSB_SH - {ci, 2'b00}));
        lz       = blank && lead && nib == 4'd0 && ci != LAST;
        ch       = lz ? 8'h20 : (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
        nb       = state == PWR_WAIT ? 8'h38 :
                   state == SNAP     ? 8'h80 :
                   state == INIT     ? (idx == 5'd0 ? 8'h0C : idx == 5'd1 ? 8'h01 : 8'h06) : ch;
        nrs      = state == HOME || state == CHAR;
        start    = (state == PWR_WAIT && pwr_end) || state == SNAP ||
                   (wr_end && (state == HOME || (state == INIT && idx != 5'd3) ||
                               (state == CHAR && idx != LAST)));
    end

    // Top sequencer and byte-writer; all bus signals are registered
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= PWR_WAIT;
            phase     <= SETUP;
            cnt       <= '0;
            idx       <= '0;
            snap      <= '0;
            blank     <= 1'b0;
            lead      <= 1'b0;
            oREADY    <= 1'b0;
            oDONE     <= 1'b0;
            oLCD_DATA <= 8'h00;
            oLCD_RS   <= 1'b0;
            oLCD_EN   <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            cnt   <= cnt + 32'd1;
            case (state)
                PWR_WAIT: if (pwr_end) state <= INIT;
                SNAP: begin
                    snap  <= iVALUE;
                    blank <= iBLANK_LZ;
                    lead  <= 1'b1;
                    state <= HOME;
                end
                DONE: state <= SNAP;
                default: if (ph_end) begin
                    cnt <= '0;
                    case (phase)
                        SETUP: begin
                            phase   <= EN_HI;
                            oLCD_EN <= 1'b1;
                        end
                        EN_HI: begin
                            phase   <= HOLD;
                            oLCD_EN <= 1'b0;
                        end
                        default: phase <= WAIT;
                    endcase
                    if (wr_end) begin
                        idx <= idx + 5'd1;
                        if (state == INIT && idx == 5'd3) begin
                            oREADY <= 1'b1;
                            state  <= SNAP;
                        end
                        if (state == HOME) begin
                            state <= CHAR;
                            idx   <= 5'd0;
                        end
                        if (state == CHAR && idx == LAST) begin
                            oDONE <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
            endcase
            if (start) begin
                oLCD_DATA <= nb;
                oLCD_RS   <= nrs;
                phase     <= SETUP;
                cnt       <= '0;
            end
            if (start && (state == HOME || state == CHAR)) lead <= lead && nib == 4'd0;
        end
    end
endmodule

// File: tb/tb_lcd_hex_display.sv
// tb_lcd_hex_display: directed vector bench for lcd_hex_display (4- and 8-digit instances)
module tb_lcd_hex_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] v4  = 16'h0000;
    logic        b4  = 1'b0;
    logic [31:0] v8  = 32'hFFFF_FFFF;
    logic        b8  = 1'b0;
    logic        rdy4, done4, rs4, rw4, en4;
    logic [7:0]  d4;
    logic        rdy8, done8, rs8, rw8, en8;
    logic [7:0]  d8;

    int n_vec = 0;
    int n_err = 0;
    int ncyc  = 0;

    logic [8:0] q4[$];
    int         tq4[$];
    logic [8:0] q8[$];

    typedef struct {
        logic [15:0] val;
        logic        blz;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    lcd_hex_display #(.DIGITS(4), .T_PWR(20), .T_SETUP(2), .T_EN(4), .T_HOLD(2), .T_CMD(8), .T_CLR(30)) dut4 (
        .iCLK(clk), .iRST(rst), .iVALUE(v4), .iBLANK_LZ(b4), .oREADY(rdy4), .oDONE(done4),
        .oLCD_DATA(d4), .oLCD_RS(rs4), .oLCD_RW(rw4), .oLCD_EN(en4));

    lcd_hex_display #(.DIGITS(8), .T_PWR(20), .T_SETUP(2), .T_EN(4), .T_HOLD(2), .T_CMD(8), .T_CLR(30)) dut8 (
        .iCLK(clk), .iRST(rst), .iVALUE(v8), .iBLANK_LZ(b8), .oREADY(rdy8), .oDONE(done8),
        .oLCD_DATA(d8), .oLCD_RS(rs8), .oLCD_RW(rw8), .oLCD_EN(en8));

    always #5 clk = ~clk;

    // Cycle counter advances on the active edge so negedge samplers see a stable value
    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor for the 4-digit instance: capture bytes and check strobe timing
    logic [8:0] prev4 = 9'h000;
    logic       pen4  = 1'b0;
    logic       chg4  = 1'b0;
    int         last_chg4 = 0;
    int         rise4 = 0;
    int         fall4 = -1000;
    always @(negedge clk) begin
        if ({rs4, d4} != prev4) begin
            if (en4 && pen4) chk("data_stable_en_hi", 0, 1);
            if (!en4 && {rs4, d4} != 9'h000) chk("hold", (ncyc - fall4 >= 2) ? 1 : 0, 1);
            last_chg4 = ncyc;
            chg4      = 1'b1;
        end
        if (en4 && !pen4) begin
            q4.push_back({rs4, d4});
            tq4.push_back(ncyc);
            if (chg4) chk("setup", ncyc - last_chg4, 2);
            rise4 = ncyc;
        end
        if (!en4 && pen4) begin
            fall4 = ncyc;
            chg4  = 1'b0;
            if ({rs4, d4} != 9'h000) chk("en_width", ncyc - rise4, 4);
        end
        prev4 = {rs4, d4};
        pen4  = en4;
    end

    // Byte capture for the 8-digit instance
    logic pen8 = 1'b0;
    always @(negedge clk) begin
        if (en8 && !pen8) q8.push_back({rs8, d8});
        pen8 = en8;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_done4();
        int k = 0;
        do begin @(negedge clk); k++; end while (!done4 && k < 1000);
        if (!done4) chk("done4_timeout", 0, 1);
    endtask

    task automatic wait_done8();
        int k = 0;
        do begin @(negedge clk); k++; end while (!done8 && k < 1000);
        if (!done8) chk("done8_timeout", 0, 1);
    endtask

    task automatic check_pass4(input string tag, input logic [31:0] exp);
        logic [8:0] got;
        chk({tag, "_n"}, q4.size(), 5);
        got = (q4.size() > 0) ? q4[0] : 9'h1FF;
        chk({tag, "_home"}, int'(got), 'h080);
        for (int j = 0; j < 4; j++) begin
            got = (q4.size() > j + 1) ? q4[j + 1] : 9'h1FF;
            chk($sformatf("%s_c%0d", tag, j), int'(got), int'({1'b1, exp[31 - 8*j -: 8]}));
        end
    endtask

    // Called at the negedge where reset has just been dropped (cycle 0)
    task automatic run_init(input string tag);
        int         t0;
        int         k;
        logic [8:0] ib[4];
        int         it[4];
        ib = '{9'h038, 9'h00C, 9'h001, 9'h006};
        it = '{22, 38, 54, 92};
        q4.delete();
        tq4.delete();
        t0 = ncyc;
        k  = 0;
        while (!en4 && k < 200) begin @(negedge clk); k++; end
        chk({tag, "_first_en"}, k, 22);
        k = 0;
        while (!rdy4 && k < 500) begin @(negedge clk); k++; end
        chk({tag, "_ready_cyc"}, ncyc - t0, 106);
        chk({tag, "_init_n"}, q4.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_init_b%0d", tag, i), (q4.size() > i) ? int'(q4[i]) : -1, int'(ib[i]));
            chk($sformatf("%s_init_t%0d", tag, i), (tq4.size() > i) ? tq4[i] - t0 : -1, it[i]);
        end
    endtask

    initial begin
        int         t1;
        int         k;
        logic [8:0] exp8;
        vecs[0] = '{16'h00A5, 1'b0, 32'h3030_4135};
        vecs[1] = '{16'h0000, 1'b1, 32'h2020_2030};
        vecs[2] = '{16'h0F00, 1'b1, 32'h2046_3030};
        vecs[3] = '{16'h0000, 1'b0, 32'h3030_3030};
        vecs[4] = '{16'h000F, 1'b1, 32'h2020_2046};
        vecs[5] = '{16'h1000, 1'b1, 32'h3130_3030};
        vecs[6] = '{16'hABCD, 1'b1, 32'h4142_4344};
        vecs[7] = '{16'h0010, 1'b1, 32'h2020_3130};

        repeat (3) @(negedge clk);
        chk("rst_en", en4, 0);
        chk("rst_data", d4, 0);
        chk("rst_rs", rs4, 0);
        chk("rst_rw", rw4, 0);
        chk("rst_ready", rdy4, 0);
        chk("rst_done", done4, 0);
        rst = 1'b0;
        run_init("pwr");

        for (int i = 0; i < 8; i++) begin
            v4 = vecs[i].val;
            b4 = vecs[i].blz;
            wait_done4();
            t1 = ncyc;
            q4.delete();
            wait_done4();
            chk($sformatf("v%0d_period", i), ncyc - t1, 82);
            check_pass4($sformatf("v%0d", i), vecs[i].exp);
        end

        v4 = 16'h1234;
        b4 = 1'b0;
        wait_done4();
        q4.delete();
        k = 0;
        while (q4.size() < 3 && k < 500) begin @(negedge clk); k++; end
        chk("coh_reach_c1", (q4.size() >= 3) ? 1 : 0, 1);
        v4 = 16'hBEEF;
        wait_done4();
        check_pass4("coh_old", 32'h3132_3334);
        q4.delete();
        wait_done4();
        check_pass4("coh_new", 32'h4245_4546);

        wait_done4();
        q4.delete();
        k = 0;
        while (!(en4 && q4.size() >= 3) && k < 500) begin @(negedge clk); k++; end
        chk("midrst_en_hi", en4, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_en", en4, 0);
        chk("midrst_data", d4, 0);
        chk("midrst_ready", rdy4, 0);
        rst = 1'b0;
        run_init("rerun");

        v8 = 32'hFFFF_FFFF;
        b8 = 1'b0;
        wait_done8();
        q8.delete();
        wait_done8();
        chk("d8_ff_n", q8.size(), 9);
        for (int j = 0; j < 9; j++) begin
            exp8 = (j == 0) ? 9'h080 : 9'h146;
            chk($sformatf("d8_ff_b%0d", j), (q8.size() > j) ? int'(q8[j]) : -1, int'(exp8));
        end
        v8 = 32'h0000_0001;
        b8 = 1'b1;
        wait_done8();
        q8.delete();
        wait_done8();
        chk("d8_one_n", q8.size(), 9);
        for (int j = 0; j < 9; j++) begin
            exp8 = (j == 0) ? 9'h080 : (j == 8) ? 9'h131 : 9'h120;
            chk($sformatf("d8_one_b%0d", j), (q8.size() > j) ? int'(q8[j]) : -1, int'(exp8));
        end
        chk("rw_const", rw8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_hex_display.md
# lcd_hex_display

Parametrised HD44780-style character-LCD driver that shows a `4*DIGITS`-bit value as `DIGITS` upper-case hex characters on line 1. It is the successor to the fixed two-digit LCD display block and sits between a top-level design and the board's 16x2 LCD pins. It adds configurable digit count, cycle-exact bus timing parameters, optional leading-zero blanking, coherent per-pass value snapshots, and ready/done status. The block is write-only: RW is held low and the data bus is output-only.

## Interface
- `DIGITS`, 4: number of hex characters shown, 1..16.
- `T_PWR`, 2_000_000: power-up wait after reset, in cycles (40 ms at 50 MHz).
- `T_SETUP`, 4: cycles that RS/DATA are stable before EN rises, ≥1.
- `T_EN`, 16: EN high width in cycles, ≥1.
- `T_HOLD`, 4: cycles that RS/DATA are held after EN falls, ≥1.
- `T_CMD`, 2_500: post-write wait for all bytes except clear, ≥0.
- `T_CLR`, 100_000: post-write wait after the clear command 0x01, ≥0.

Ports:
- `iCLK` input 1: single clock; all logic on the rising edge.
- `iRST` input 1: synchronous, active-high reset.
- `iVALUE` input 4*DIGITS: value to display, MSB nibble leftmost.
- `iBLANK_LZ` input 1: 1 = leading zeros shown as spaces. Sampled with the snapshot.
- `oREADY` output 1: high once the init sequence has completed.
- `oDONE` output 1: one-cycle pulse at the end of each display pass.
- `oLCD_DATA` output 8: LCD data bus.
- `oLCD_RS` output 1: 0 = command, 1 = data.
- `oLCD_RW` output 1: constant 0.
- `oLCD_EN` output 1: LCD enable strobe.

## Operation
- Reset values: `oLCD_EN`=0, `oLCD_RS`=0, `oLCD_RW`=0, `oLCD_DATA`=0x00, `oREADY`=0, `oDONE`=0. All counters, indices and the snapshot register are cleared to 0.
- Top FSM states:
  - PWR_WAIT: waits `T_PWR` cycles.
  - INIT: writes 0x38, 0x0C, 0x01, 0x06 in order with RS=0. When the last of these writes finishes, `oREADY` is set and stays high until reset.
  - SNAP: lasts 1 cycle. Latches `iVALUE` and `iBLANK_LZ`.
  - HOME: writes 0x80 with RS=0.
  - CHAR: writes `DIGITS` bytes with RS=1, from the most significant nibble to the least.
  - After the last CHAR write, `oDONE` pulses for 1 cycle, then the FSM goes to SNAP. Refresh runs continuously.
- Byte-writer sub-FSM: SETUP, EN_HI, HOLD, WAIT.
  - RS/DATA are driven on the first SETUP cycle and held through the end of HOLD.
  - WAIT lasts `T_CLR` cycles for byte 0x01 and `T_CMD` cycles for every other byte.
  - Each write occupies exactly `T_SETUP+T_EN+T_HOLD+wait` cycles.
- Nibble encoding: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46.
- Leading-zero blanking (when the snapshot of `iBLANK_LZ` is 1):
  - Each zero nibble before the first non-zero nibble is sent as 0x20.
  - The least significant character is never blanked, so value 0 displays as "…0".
- Coherency: every character in a pass comes from that pass's snapshot. Changes to `iVALUE` mid-pass affect only the next pass.
- Reset mid-operation: on the cycle after `iRST` is sampled high, all outputs return to their reset values, including `oLCD_EN` dropping immediately. The full PWR_WAIT and INIT sequence is then repeated.

## Timing
- EN rises exactly `T_SETUP` cycles after RS/DATA change. It is high for exactly `T_EN` cycles.
- RS/DATA change no earlier than `T_HOLD` cycles after EN falls.
- First EN rise after reset deasserts: cycle `T_PWR+T_SETUP`, counting the first cycle with `iRST` low as cycle 0.
- Write cost: `W(b)=T_SETUP+T_EN+T_HOLD+(b==0x01?T_CLR:T_CMD)`.
- Pass period, from one `oDONE` to the next: `1 + (DIGITS+1)*W_cmd + 1`, where `W_cmd` uses `T_CMD`. The terms are SNAP, the writes, and the DONE cycle.
- `oREADY` rises on the cycle after the final WAIT of byte 0x06 ends.

## Test plan
Default bench parameters: `DIGITS`=4, `T_PWR`=20, `T_SETUP`=2, `T_EN`=4, `T_HOLD`=2, `T_CMD`=8, `T_CLR`=30.

1. Release reset.
   - EN stays 0 for 22 cycles.
   - Then bytes 0x38, 0x0C, 0x01, 0x06 appear with RS=0. Each EN pulse is exactly 4 cycles wide.
   - The gap after 0x01 is 30 cycles. `oREADY` then rises.
2. `iVALUE`=0x00A5, `iBLANK_LZ`=0.
   - Bytes 0x80 (RS=0), then 0x30, 0x30, 0x41, 0x35 (RS=1).
   - One `oDONE` pulse. Next `oDONE` follows 1+5*16+1 = 82 cycles later.
3. `iBLANK_LZ`=1.
   - `iVALUE`=0x0000 gives 0x20, 0x20, 0x20, 0x30.
   - `iVALUE`=0x0F00 gives 0x20, 0x46, 0x30, 0x30.
4. Change `iVALUE` from 0x1234 to 0xBEEF during the second CHAR write.
   - That pass shows 0x31, 0x32, 0x33, 0x34.
   - The following pass shows 0x42, 0x45, 0x45, 0x46.
5. Assert `iRST` for 1 cycle while EN is high in CHAR.
   - Next cycle: EN=0, DATA=0x00, `oREADY`=0.
   - The full power-up wait and init sequence repeat, with identical timing to scenario 1.
6. `DIGITS`=8, `iVALUE`=0xFFFFFFFF, then 0x00000001 with blanking on.
   - First value: 0x80 followed by eight 0x46.
   - Second value: seven 0x20 then 0x31.
